// File: rtl/ce_sample_player_if.sv
// Bundle for the ce_sample_player buffer-write, playback control
// and 14-bit sample/strobe output signals.
interface ce_sample_player_if #(
   parameter int AW = 5
);
   logic               i_wr_en;
   logic [AW-1:0]      i5_wr_addr;
   logic signed [13:0] is14_wr_data;
   logic               i_start;
   logic               i_stop;
   logic               i_loop;
   logic [AW-1:0]      i5_last;
   logic [31:0]        i32_prescaler;
   logic signed [13:0] os14_data;
   logic               o_ce;
   logic               o_busy;
   logic               o_done;

   modport master (
      output i_wr_en, i5_wr_addr, is14_wr_data,
      output i_start, i_stop, i_loop,
      output i5_last, i32_prescaler,
      input  os14_data, o_ce, o_busy, o_done
   );

   modport slave (
      input  i_wr_en, i5_wr_addr, is14_wr_data,
      input  i_start, i_stop, i_loop,
      input  i5_last, i32_prescaler,
      output os14_data, o_ce, o_busy, o_done
   );
endinterface

// File: rtl/ce_sample_player.sv
// Circular-buffer sample player: emits one 14-bit sample per
// prescaler period with an aligned one-cycle ce strobe.
module ce_sample_player #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input logic          clk,
   input logic          rstn,
   ce_sample_player_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_e;

   state_e state_q, state_d;

   logic [31:0]        p_q, p_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               loop_q, loop_d;
   logic [AW-1:0]      last_q, last_d;
   logic [AW-1:0]      ptr_q, ptr_d;
   logic signed [13:0] data_q, data_d;
   logic               ce_q, ce_d;
   logic               done_q, done_d;
   logic               tick;
   logic signed [13:0] rd_data;

   logic signed [13:0] mem [DEPTH];

   // Combinational read sees the pre-write contents on a collision.
   assign rd_data = mem[ptr_q];

   always_ff @(posedge clk) begin
      if (bus.i_wr_en) begin
         mem[bus.i5_wr_addr] <= bus.is14_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      loop_d  = loop_q;
      last_d  = last_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      ce_d    = 1'b0;
      done_d  = 1'b0;
      tick    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_start && !bus.i_stop) begin
               state_d = ST_RUN;
               p_d     = (bus.i32_prescaler == 32'd0)
                         ? 32'd1 : bus.i32_prescaler;
               loop_d  = bus.i_loop;
               last_d  = bus.i5_last;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (bus.i_stop) begin
               state_d = ST_IDLE;
            end else begin
               tick = (cnt_q == p_q - 32'd1);
               if (tick) begin
                  cnt_d  = '0;
                  data_d = rd_data;
                  ce_d   = 1'b1;
                  if (ptr_q == last_q) begin
                     if (loop_q) begin
                        ptr_d = '0;
                     end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end else begin
                     ptr_d = ptr_q + AW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         p_q     <= 32'd1;
         cnt_q   <= '0;
         loop_q  <= 1'b0;
         last_q  <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         ce_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         loop_q  <= loop_d;
         last_q  <= last_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         ce_q    <= ce_d;
         done_q  <= done_d;
      end
   end

   assign bus.os14_data = data_q;
   assign bus.o_ce      = ce_q;
   assign bus.o_done    = done_q;
   // Busy stays up through the done cycle and drops the cycle after.
   assign bus.o_busy    = (state_q == ST_RUN) | done_q;

endmodule

// File: tb/tb_ce_sample_player.sv
// Randomized self-checking bench for ce_sample_player against a
// strobe-schedule model (strobe k at k*P cycles after start).
module tb_ce_sample_player;

   logic clk;
   logic rstn;

   ce_sample_player_if #(.AW(5)) bus ();

   ce_sample_player #(.DEPTH(32), .AW(5)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [13:0] ref_mem [32];
   logic signed [13:0] exp_data;

   task automatic chk(input string tag, input int t,
                      input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %0d want %0d",
                  tag, t, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.i_wr_en       = 1'b0;
      bus.i5_wr_addr    = '0;
      bus.is14_wr_data  = '0;
      bus.i_start       = 1'b0;
      bus.i_stop        = 1'b0;
      bus.i_loop        = 1'b0;
      bus.i5_last       = '0;
      bus.i32_prescaler = '0;
   endtask

   task automatic write_mem(input int a, input int v);
      @(negedge clk);
      bus.i_wr_en      = 1'b1;
      bus.i5_wr_addr   = a[4:0];
      bus.is14_wr_data = v[13:0];
      ref_mem[a]       = v[13:0];
   endtask

   task automatic check_quiet(input string tag, input int ncyc);
      for (int t = 0; t < ncyc; t++) begin
         @(negedge clk);
         chk({tag, "_ce"}, t, bus.o_ce, 0);
         chk({tag, "_busy"}, t, bus.o_busy, 0);
         chk({tag, "_done"}, t, bus.o_done, 0);
         chk({tag, "_data"}, t, bus.os14_data, exp_data);
      end
   endtask

   function automatic bit strobe_at(input int t, input int p,
                                    input int n, input bit loop,
                                    input int stop_t);
      if (stop_t >= 0 && t > stop_t) return 1'b0;
      if (t <= 0 || (t % p) != 0) return 1'b0;
      return loop || (t / p <= n);
   endfunction

   // t counts negedges after the edge that sampled i_start (t=0 first).
   task automatic run(input int p_in, input int last, input bit loop,
                      input int ncyc, input int stop_t,
                      input int wr_t, input int wr_a, input int wr_v);
      int p;
      int n;
      bit st;
      bit busy;
      bit done;
      bit stopped;
      logic signed [13:0] pend;
      p    = (p_in == 0) ? 1 : p_in;
      n    = last + 1;
      pend = exp_data;
      @(negedge clk);
      idle_inputs();
      bus.i_start       = 1'b1;
      bus.i_loop        = loop;
      bus.i5_last       = last[4:0];
      bus.i32_prescaler = p_in;
      for (int t = 0; t <= ncyc; t++) begin
         @(negedge clk);
         stopped = (stop_t >= 0 && t > stop_t);
         st      = strobe_at(t, p, n, loop, stop_t);
         if (st) exp_data = pend;
         done = st && !loop && (t / p == n);
         busy = !stopped && (loop || t <= n * p);
         chk("ce", t, bus.o_ce, st);
         chk("done", t, bus.o_done, done);
         chk("busy", t, bus.o_busy, busy);
         chk("data", t, bus.os14_data, exp_data);
         if (strobe_at(t + 1, p, n, loop, stop_t)) begin
            pend = ref_mem[((t + 1) / p - 1) % n];
         end
         bus.i_start = 1'b0;
         bus.i_stop  = (t == stop_t);
         if (t == wr_t) begin
            bus.i_wr_en      = 1'b1;
            bus.i5_wr_addr   = wr_a[4:0];
            bus.is14_wr_data = wr_v[13:0];
            ref_mem[wr_a]    = wr_v[13:0];
         end else begin
            bus.i_wr_en = 1'b0;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      int p;
      int pe;
      int last;
      int n;
      bit lp;
      int stop_t;
      int ncyc;
      idle_inputs();
      exp_data = '0;
      rstn     = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      check_quiet("rst", 8);

      write_mem(0, 100);
      write_mem(1, -200);
      write_mem(2, 300);
      write_mem(3, -400);
      run(4, 3, 1'b0, 22, -1, -1, 0, 0);

      run(1, 3, 1'b1, 14, 12, -1, 0, 0);

      run(0, 3, 1'b1, 12, 9, -1, 0, 0);

      run(2, 3, 1'b1, 16, 14, 3, 1, 777);

      @(negedge clk);
      bus.i_start       = 1'b1;
      bus.i_stop        = 1'b1;
      bus.i32_prescaler = 32'd1;
      @(negedge clk);
      idle_inputs();
      check_quiet("startstop", 6);

      @(negedge clk);
      bus.i_start       = 1'b1;
      bus.i_loop        = 1'b1;
      bus.i5_last       = 5'd3;
      bus.i32_prescaler = 32'd4;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (6) @(negedge clk);
      rstn = 1'b0;
      exp_data = '0;
      @(negedge clk);
      chk("midrst_ce", 0, bus.o_ce, 0);
      chk("midrst_busy", 0, bus.o_busy, 0);
      chk("midrst_done", 0, bus.o_done, 0);
      chk("midrst_data", 0, bus.os14_data, 0);
      rstn = 1'b1;
      idle_inputs();
      check_quiet("postrst", 12);

      for (int a = 0; a < 32; a++) write_mem(a, 1000);
      run(500, 31, 1'b0, 1501, 1498, -1, 0, 0);

      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 32; a++) begin
            write_mem(a, $urandom_range(0, 16383));
         end
         p    = $urandom_range(0, 5);
         pe   = (p == 0) ? 1 : p;
         last = $urandom_range(0, 7);
         n    = last + 1;
         lp   = 1'($urandom_range(0, 1));
         if (lp) begin
            stop_t = $urandom_range(pe, 3 * n * pe);
            ncyc   = stop_t + 3;
         end else begin
            stop_t = -1;
            ncyc   = n * pe + 3;
         end
         run(p, last, lp, ncyc, stop_t,
             $urandom_range(0, ncyc - 1),
             $urandom_range(0, last),
             $urandom_range(0, 16383));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ce_sample_player.md
Name: ce_sample_player

Overview:
- 14-bit sample source that drives the filter input side of the signal chain: `os14_data` connects to a filter's `is14_in`/`is14_data`, and `o_ce` connects to its `ce`.
- Software loads a waveform into a 32-entry circular buffer, then starts playback.
- One sample is emitted per prescaler period, with a one-cycle `o_ce` strobe aligned to the data.
- Playback is one-shot or looped. It is used for on-board filter stimulus and for bench stimulus of filter blocks.

Parameters:
- DEPTH, 32, number of buffer entries (power of two).
- AW, 5, address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock (100 MHz).
- rstn  in  1  synchronous reset, active-low.
- i_wr_en  in  1  buffer write strobe.
- i5_wr_addr  in  AW  buffer write address.
- is14_wr_data  in  14  signed sample to write.
- i_start  in  1  start playback (pulse or level).
- i_stop  in  1  abort playback.
- i_loop  in  1  1 = wrap and repeat, 0 = one-shot. Sampled at start.
- i5_last  in  AW  index of the last sample to play. Sampled at start.
- i32_prescaler  in  32  clocks per sample. Sampled at start. 0 is treated as 1.
- os14_data  out  14  signed sample output, registered.
- o_ce  out  1  one-cycle strobe marking a new os14_data value.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse on the final sample of a one-shot run.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State returns to IDLE.
  - os14_data=0, o_ce=0, o_busy=0, o_done=0.
  - Read pointer and prescaler counter are cleared.
  - Buffer contents are not cleared.
  - Reset mid-run aborts immediately, with no further strobes.
- Buffer write:
  - Synchronous write, accepted in any state.
  - A write to the address being read on a tick cycle returns the old data (read-before-write).
- Prescaler:
  - P = max(i32_prescaler, 1), latched at start.
  - The counter runs 0..P-1. tick = (RUN and counter==P-1), after which the counter wraps to 0.
  - P=1 gives an o_ce every cycle.
- FSM IDLE:
  - o_busy=0.
  - If i_start=1 and i_stop=0: latch P, i_loop and i5_last; ptr=0, counter=0; go to RUN.
  - i_start together with i_stop: remain in IDLE.
- FSM RUN:
  - o_busy=1.
  - On tick, registered at the next edge: os14_data=mem[ptr], o_ce=1.
  - If ptr==last: when loop=1, ptr=0 and stay in RUN; when loop=0, o_done=1 (same cycle as the final o_ce) and go to IDLE.
  - Otherwise ptr increments.
  - i_stop=1: go to IDLE at the next edge, with no o_ce and no o_done. A tick in the same cycle as i_stop is suppressed.
  - i_start is ignored while in RUN.
- Latency:
  - The first o_ce is high during the cycle that starts P edges after the edge that sampled i_start.
  - Subsequent o_ce strobes follow every P cycles exactly.
- os14_data holds its last value between strobes and after stop or done.
- o_ce is never high for more than one cycle when P>1.
- i5_last=0 plays a single sample (one-shot) or repeats mem[0] (loop).

Test Plan:
- Reset then idle: drive rstn=0 for 3 cycles, then hold all inputs at 0 → outputs stay 0 and o_ce never asserts.
- One-shot run:
  - Write mem[0..3] = 100, -200, 300, -400. Set i5_last=3, P=4, loop=0, then pulse start.
  - Required: 4 o_ce pulses spaced 4 cycles apart, the first 4 cycles after start.
  - Data sequence 100, -200, 300, -400.
  - o_done coincides with the 4th o_ce; o_busy falls on the next cycle.
- Loop with wrap: same buffer with loop=1, P=1 → o_ce continuous; data cycles 100, -200, 300, -400, 100, … for 12 cycles, and o_done never asserts.
- Stop mid-run: P=500, data 1000 at all entries, i5_last=31. Assert stop 1 cycle before the 3rd tick → exactly 2 o_ce, then o_busy=0 and os14_data holds 1000.
- Corner cases:
  - P=0 behaves identically to P=1.
  - i_start and i_stop together in IDLE → no run starts.
  - Reset asserted during a run at P=4 → all outputs 0 next cycle, and no strobe follows reset release.
- Write during playback: loop run with P=2, write mem[ptr] in the tick cycle → the old value is emitted now and the new value on the next wrap.
